core_run_ctrl: RTL and testbench
================================

Name: core_run_ctrl

Overview:
- Host-side sequencer for the ridecore top-level.
- Preloads instruction and data memory through a valid/ready command port, then holds the core in reset for a fixed number of cycles.
- Releases the core and counts run cycles.
- Stops the core on a halt store (a store to a magic data address) or on a cycle-limit timeout, and reports the result.

Parameters:
- MEM_AW, 8, word-address width shared by the IMEM and DMEM write ports and cmd_addr
- DATA_W, 32, memory word and exit-code width
- CNT_W, 32, cycle counter and run_limit width
- RST_CYCLES, 10, number of cycles core_reset_x is held low before RUN (must be ≥1)
- HALT_ADDR, 8'hFF, DMEM word address whose store ends the run

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_op  in  2  0=WR_IMEM, 1=WR_DMEM, 2=START, 3=ABORT
- cmd_addr  in  MEM_AW  write word address
- cmd_data  in  DATA_W  write data
- run_limit  in  CNT_W  max RUN cycles, sampled at START; 0 = unlimited
- imem_we / imem_waddr / imem_wdata  out  1 / MEM_AW / DATA_W  IMEM write port
- dmem_we / dmem_waddr / dmem_wdata  out  1 / MEM_AW / DATA_W  DMEM write port
- core_reset_x  out  1  active-low reset to the core
- mon_we / mon_addr / mon_data  in  1 / MEM_AW / DATA_W  core store monitor
- busy  out  1  high in RST_HOLD or RUN
- done  out  1  high in DONE
- halted  out  1  in DONE: 1 = halt store, 0 = timeout
- exit_code  out  DATA_W  mon_data of the halting store
- cycle_count  out  CNT_W  RUN cycles elapsed

Behaviour:
- Reset (async, any state): state=IDLE, core_reset_x=0, imem_we=dmem_we=0, waddr/wdata=0, busy=done=halted=0, exit_code=0, cycle_count=0, internal limit and hold counter=0.
- FSM states: IDLE, RST_HOLD, RUN, DONE. Outputs are registered, except that cmd_ready is combinational.
- cmd_ready is 1 in IDLE and DONE for every op. In RST_HOLD and RUN it equals (cmd_op==ABORT).
- Accepted WR_IMEM/WR_DMEM: the selected port pulses we=1 for exactly one cycle on the next edge, with addr/data registered. This gives 1-cycle latency and back-to-back writes every cycle. The other port's we stays 0.
- Writes in DONE are legal; they do not change state or the result outputs.
- START (from IDLE or DONE):
  - next state RST_HOLD; hold counter=RST_CYCLES-1
  - cycle_count=0, done=halted=0, exit_code=0
  - run_limit latched
- RST_HOLD: core_reset_x=0 and busy=1. The counter decrements each cycle; at 0 the FSM enters RUN, so core_reset_x is low for exactly RST_CYCLES cycles after START is accepted.
- RUN:
  - core_reset_x=1; cycle_count increments each cycle, saturating at all-ones.
  - Halt: mon_we && mon_addr==HALT_ADDR → DONE, halted=1, exit_code=mon_data, core_reset_x=0 next cycle. cycle_count includes the halting cycle.
  - Timeout: limit≠0 and cycle_count+1==limit → DONE, halted=0, cycle_count=limit.
  - Halt and timeout in the same cycle: halt wins (halted=1).
  - mon_* is ignored outside RUN.
- DONE: core_reset_x=0, done=1, busy=0; results are held until the next START, ABORT or rst.
- ABORT (any state):
  - next state IDLE, core_reset_x=0
  - done=halted=0, cycle_count=0, exit_code=0
  - any pending write pulse from the same cycle is not generated
- START in IDLE or DONE while a write pulse is in flight: the pulse completes normally, because the pulse register is independent of the FSM.

Decomposition:
- Package core_run_pkg:
  - op codes OP_WR_IMEM/OP_WR_DMEM/OP_START/OP_ABORT
  - state enum (IDLE, RST_HOLD, RUN, DONE)
  - localparam widths of the op field
- One natural sub-module, run_cycle_counter: a CNT_W saturating counter with clear/enable and a limit-compare output (hit = limit≠0 && next==limit).

Test Plan:
- Load: WR_IMEM addr 0..3 with data 0x13, 0x93, 0x113, 0x193 on consecutive cycles → four consecutive imem_we pulses, each one cycle after acceptance, with matching addr/data; dmem_we stays 0.
- Reset hold: START with RST_CYCLES=10 and run_limit=0 → core_reset_x low exactly 10 cycles after acceptance, busy=1, then core_reset_x=1 and cycle_count counting from 1.
- Halt: in RUN at cycle 37, mon_we=1, mon_addr=0xFF, mon_data=0x2A → next cycle done=1, halted=1, exit_code=0x2A, cycle_count=37, core_reset_x=0.
- Timeout and priority:
  - run_limit=50 with no halt → done=1, halted=0, cycle_count=50.
  - repeat with the halt store on cycle 50 → halted=1.
- Abort: ABORT issued in RUN at cycle 20 → cmd_ready=1 for ABORT and 0 for WR_IMEM that cycle, next state IDLE, core_reset_x=0, cycle_count=0.
- Async reset: assert rst mid-RUN, between clock edges → all outputs return to reset values immediately; after release a START behaves as the first run.

Source files
------------

// File: rtl/core_run_pkg.sv
// Shared types for the run controller: host command opcodes and FSM states.
package core_run_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_WR_IMEM = 2'd0,
    OP_WR_DMEM = 2'd1,
    OP_START   = 2'd2,
    OP_ABORT   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RST_HOLD = 2'd1,
    ST_RUN      = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating run-cycle counter with synchronous clear/enable and a limit compare.
// Ports:
//   clk, rst     clock, async active-high reset
//   clr_i        clear count to 0 (wins over en_i)
//   en_i         advance count by one (saturates at all-ones)
//   limit_i      compare value; 0 disables the compare
//   count_o      registered count
//   hit_c_o      combinational: limit_i != 0 and the next count equals limit_i
module run_cycle_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             hit_c_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] next_c;

  // Saturating increment
  assign next_c = (count_q == '1) ? count_q : count_q + CNT_W'(1);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = next_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign hit_c_o = (limit_i != '0) && (next_c == limit_i);

endmodule

// File: rtl/core_run_ctrl.sv
// Host-side sequencer for the core: preloads IMEM/DMEM, holds the core in reset,
// runs it, and stops on a halt store or cycle-limit timeout.
// Ports:
//   clk, rst                      clock, async active-high reset
//   cmd_valid/cmd_ready/cmd_op    host command handshake (cmd_ready is combinational)
//   cmd_addr/cmd_data             write word address / data
//   run_limit                     max RUN cycles, sampled at START (0 = unlimited)
//   imem_we/waddr/wdata           IMEM write port (one-cycle pulses)
//   dmem_we/waddr/wdata           DMEM write port (one-cycle pulses)
//   core_reset_x                  active-low reset to the core
//   mon_we/mon_addr/mon_data      core store monitor
//   busy/done/halted/exit_code    run status and result
//   cycle_count                   RUN cycles elapsed
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int unsigned       MEM_AW     = 8,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       CNT_W      = 32,
  parameter int unsigned       RST_CYCLES = 10,
  parameter logic [MEM_AW-1:0] HALT_ADDR  = MEM_AW'(8'hFF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [MEM_AW-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CNT_W-1:0]  run_limit,
  output logic              imem_we,
  output logic [MEM_AW-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              dmem_we,
  output logic [MEM_AW-1:0] dmem_waddr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              core_reset_x,
  input  logic              mon_we,
  input  logic [MEM_AW-1:0] mon_addr,
  input  logic [DATA_W-1:0] mon_data,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic [DATA_W-1:0] exit_code,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned       HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYCLES - 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic              core_reset_x_q, core_reset_x_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              halted_q, halted_d;
  logic [DATA_W-1:0] exit_q, exit_d;

  logic              imem_we_q, imem_we_d;
  logic [MEM_AW-1:0] imem_waddr_q, imem_waddr_d;
  logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
  logic              dmem_we_q, dmem_we_d;
  logic [MEM_AW-1:0] dmem_waddr_q, dmem_waddr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;

  op_e               op_c;
  logic              acc_c;
  logic              halt_c;
  logic              hit_c;
  logic              cnt_clr_c;
  logic              cnt_en_c;

  assign op_c   = op_e'(cmd_op);
  assign halt_c = mon_we && (mon_addr == HALT_ADDR);

  // While the core is held or running only ABORT may be accepted
  always_comb begin
    cmd_ready = 1'b1;
    if ((state_q == ST_RST_HOLD) || (state_q == ST_RUN)) begin
      cmd_ready = (op_c == OP_ABORT);
    end
  end

  assign acc_c = cmd_valid && cmd_ready;

  // Write pulse path, independent of the FSM
  always_comb begin
    imem_we_d    = acc_c && (op_c == OP_WR_IMEM);
    dmem_we_d    = acc_c && (op_c == OP_WR_DMEM);
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_waddr_d = dmem_waddr_q;
    dmem_wdata_d = dmem_wdata_q;
    if (imem_we_d) begin
      imem_waddr_d = cmd_addr;
      imem_wdata_d = cmd_data;
    end
    if (dmem_we_d) begin
      dmem_waddr_d = cmd_addr;
      dmem_wdata_d = cmd_data;
    end
  end

  // Run sequencing FSM
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    limit_d   = limit_q;
    halted_d  = halted_q;
    exit_d    = exit_q;
    cnt_clr_c = 1'b0;
    cnt_en_c  = 1'b0;

    if (acc_c && (op_c == OP_ABORT)) begin
      state_d   = ST_IDLE;
      halted_d  = 1'b0;
      exit_d    = '0;
      cnt_clr_c = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (acc_c && (op_c == OP_START)) begin
            state_d   = ST_RST_HOLD;
            hold_d    = HOLD_INIT;
            limit_d   = run_limit;
            halted_d  = 1'b0;
            exit_d    = '0;
            cnt_clr_c = 1'b1;
          end
        end
        ST_RST_HOLD: begin
          if (hold_q == '0) begin
            state_d = ST_RUN;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        ST_RUN: begin
          // The halting / timing-out cycle is itself counted
          cnt_en_c = 1'b1;
          if (halt_c) begin
            state_d  = ST_DONE;
            halted_d = 1'b1;
            exit_d   = mon_data;
          end else if (hit_c) begin
            state_d  = ST_DONE;
            halted_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d         = (state_d == ST_RST_HOLD) || (state_d == ST_RUN);
    done_d         = (state_d == ST_DONE);
    core_reset_x_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      hold_q         <= '0;
      limit_q        <= '0;
      core_reset_x_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      halted_q       <= 1'b0;
      exit_q         <= '0;
      imem_we_q      <= 1'b0;
      imem_waddr_q   <= '0;
      imem_wdata_q   <= '0;
      dmem_we_q      <= 1'b0;
      dmem_waddr_q   <= '0;
      dmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      limit_q        <= limit_d;
      core_reset_x_q <= core_reset_x_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      halted_q       <= halted_d;
      exit_q         <= exit_d;
      imem_we_q      <= imem_we_d;
      imem_waddr_q   <= imem_waddr_d;
      imem_wdata_q   <= imem_wdata_d;
      dmem_we_q      <= dmem_we_d;
      dmem_waddr_q   <= dmem_waddr_d;
      dmem_wdata_q   <= dmem_wdata_d;
    end
  end

  run_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr_c),
    .en_i    (cnt_en_c),
    .limit_i (limit_q),
    .count_o (cycle_count),
    .hit_c_o (hit_c)
  );

  assign core_reset_x = core_reset_x_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign halted       = halted_q;
  assign exit_code    = exit_q;
  assign imem_we      = imem_we_q;
  assign imem_waddr   = imem_waddr_q;
  assign imem_wdata   = imem_wdata_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_waddr   = dmem_waddr_q;
  assign dmem_wdata   = dmem_wdata_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: table-driven write vectors with a
// scoreboard queue, plus hand-written run/halt/timeout/abort/reset sequences.
module tb_core_run_ctrl;
  import core_run_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [31:0] run_limit;
  logic        imem_we, dmem_we;
  logic [7:0]  imem_waddr, dmem_waddr;
  logic [31:0] imem_wdata, dmem_wdata;
  logic        core_reset_x;
  logic        mon_we;
  logic [7:0]  mon_addr;
  logic [31:0] mon_data;
  logic        busy, done, halted;
  logic [31:0] exit_code;
  logic [31:0] cycle_count;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        imem_we;
    logic        dmem_we;
    logic        chk_ad;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
    exp_t        exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  core_run_ctrl #(
    .MEM_AW(8), .DATA_W(32), .CNT_W(32), .RST_CYCLES(10), .HALT_ADDR(8'hFF)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .run_limit(run_limit),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .core_reset_x(core_reset_x),
    .mon_we(mon_we), .mon_addr(mon_addr), .mon_data(mon_data),
    .busy(busy), .done(done), .halted(halted),
    .exit_code(exit_code), .cycle_count(cycle_count)
  );

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one table record, queue its expectation, compare one edge later
  task automatic apply_vec(input vec_t v, input string nm);
    exp_t e;
    cmd_valid = v.valid;
    cmd_op    = v.op;
    cmd_addr  = v.addr;
    cmd_data  = v.data;
    #1;
    if (v.valid) check({nm, "_ready"}, 64'(cmd_ready), 64'd1);
    sb_q.push_back(v.exp);
    tick();
    e = sb_q.pop_front();
    check({nm, "_imem_we"}, 64'(imem_we), 64'(e.imem_we));
    check({nm, "_dmem_we"}, 64'(dmem_we), 64'(e.dmem_we));
    if (e.chk_ad) begin
      if (e.imem_we) begin
        check({nm, "_imem_waddr"}, 64'(imem_waddr), 64'(e.addr));
        check({nm, "_imem_wdata"}, 64'(imem_wdata), 64'(e.data));
      end else begin
        check({nm, "_dmem_waddr"}, 64'(dmem_waddr), 64'(e.addr));
        check({nm, "_dmem_wdata"}, 64'(dmem_wdata), 64'(e.data));
      end
    end
  endtask

  task automatic start_run(input logic [31:0] lim, input string nm);
    cmd_valid = 1'b1;
    cmd_op    = OP_START;
    run_limit = lim;
    #1;
    check({nm, "_start_ready"}, 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Count samples with core_reset_x low after START acceptance
  task automatic measure_hold(input string nm);
    int low = 0;
    int busy_bad = 0;
    while (!core_reset_x && low < 40) begin
      if (!busy) busy_bad++;
      low++;
      tick();
    end
    check({nm, "_hold_len"}, 64'(low), 64'd10);
    check({nm, "_hold_busy"}, 64'(busy_bad), 64'd0);
    check({nm, "_run_busy"}, 64'(busy), 64'd1);
    check({nm, "_run_cnt0"}, 64'(cycle_count), 64'd0);
  endtask

  task automatic wait_count(input logic [31:0] tgt, input string nm);
    int n = 0;
    while (cycle_count != tgt && n < 500) begin
      tick();
      n++;
    end
    check({nm, "_reach"}, 64'(cycle_count), 64'(tgt));
  endtask

  task automatic halt_store(input logic [31:0] code);
    mon_we   = 1'b1;
    mon_addr = 8'hFF;
    mon_data = code;
    tick();
    mon_we   = 1'b0;
    mon_addr = 8'h00;
    mon_data = 32'h0;
  endtask

  initial begin
    vec_t vd;
    int   n;
    vecs[0] = '{1'b1, 2'd0, 8'd0, 32'h13,   '{1'b1, 1'b0, 1'b1, 8'd0, 32'h13}};
    vecs[1] = '{1'b1, 2'd0, 8'd1, 32'h93,   '{1'b1, 1'b0, 1'b1, 8'd1, 32'h93}};
    vecs[2] = '{1'b1, 2'd0, 8'd2, 32'h113,  '{1'b1, 1'b0, 1'b1, 8'd2, 32'h113}};
    vecs[3] = '{1'b1, 2'd0, 8'd3, 32'h193,  '{1'b1, 1'b0, 1'b1, 8'd3, 32'h193}};
    vecs[4] = '{1'b1, 2'd1, 8'd5, 32'hDEAD, '{1'b0, 1'b1, 1'b1, 8'd5, 32'hDEAD}};
    vecs[5] = '{1'b0, 2'd0, 8'd9, 32'h99,   '{1'b0, 1'b0, 1'b0, 8'd0, 32'h0}};
    vecs[6] = '{1'b1, 2'd1, 8'd6, 32'hBEEF, '{1'b0, 1'b1, 1'b1, 8'd6, 32'hBEEF}};
    vd      = '{1'b1, 2'd1, 8'd7, 32'h77,   '{1'b0, 1'b1, 1'b1, 8'd7, 32'h77}};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 8'd0; cmd_data = 32'd0;
    run_limit = 32'd0; mon_we = 1'b0; mon_addr = 8'd0; mon_data = 32'd0;
    tick();
    tick();
    check("rst_core_reset_x", 64'(core_reset_x), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_exit", 64'(exit_code), 64'd0);
    check("rst_count", 64'(cycle_count), 64'd0);
    check("rst_imem_we", 64'(imem_we), 64'd0);
    check("rst_imem_waddr", 64'(imem_waddr), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    rst = 1'b0;

    // Preload: back-to-back writes
    for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("load%0d", i));
    cmd_valid = 1'b0;

    // Reset hold then unlimited run ended by a halt store at cycle 37
    start_run(32'd0, "run1");
    measure_hold("run1");
    tick();
    check("run1_cnt1", 64'(cycle_count), 64'd1);
    mon_we = 1'b1; mon_addr = 8'h10; mon_data = 32'h1;
    tick();
    mon_we = 1'b0;
    check("run1_nonhalt_done", 64'(done), 64'd0);
    check("run1_nonhalt_cnt", 64'(cycle_count), 64'd2);
    wait_count(32'd36, "run1");
    halt_store(32'h2A);
    check("halt_done", 64'(done), 64'd1);
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_exit", 64'(exit_code), 64'h2A);
    check("halt_count", 64'(cycle_count), 64'd37);
    check("halt_core_reset_x", 64'(core_reset_x), 64'd0);
    check("halt_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    check("halt_hold_count", 64'(cycle_count), 64'd37);
    apply_vec(vd, "done_wr");
    cmd_valid = 1'b0;
    check("done_wr_done", 64'(done), 64'd1);
    check("done_wr_halted", 64'(halted), 64'd1);
    check("done_wr_exit", 64'(exit_code), 64'h2A);

    // Timeout at run_limit=50
    start_run(32'd50, "to");
    check("to_cleared_done", 64'(done), 64'd0);
    check("to_cleared_exit", 64'(exit_code), 64'd0);
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    check("to_done", 64'(done), 64'd1);
    check("to_halted", 64'(halted), 64'd0);
    check("to_count", 64'(cycle_count), 64'd50);

    // Halt on the limit cycle wins over timeout
    start_run(32'd50, "pri");
    measure_hold("pri");
    wait_count(32'd49, "pri");
    halt_store(32'h55);
    check("pri_done", 64'(done), 64'd1);
    check("pri_halted", 64'(halted), 64'd1);
    check("pri_exit", 64'(exit_code), 64'h55);
    check("pri_count", 64'(cycle_count), 64'd50);

    // Abort in RUN at cycle 20
    start_run(32'd0, "ab");
    cmd_op = OP_START;
    #1;
    check("ab_hold_ready_start", 64'(cmd_ready), 64'd0);
    measure_hold("ab");
    wait_count(32'd19, "ab");
    cmd_valid = 1'b1; cmd_op = OP_WR_IMEM; cmd_addr = 8'd1; cmd_data = 32'h1;
    #1;
    check("ab_ready_wr", 64'(cmd_ready), 64'd0);
    cmd_op = OP_ABORT;
    #1;
    check("ab_ready_abort", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    check("ab_done", 64'(done), 64'd0);
    check("ab_halted", 64'(halted), 64'd0);
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_core_reset_x", 64'(core_reset_x), 64'd0);
    check("ab_count", 64'(cycle_count), 64'd0);
    check("ab_exit", 64'(exit_code), 64'd0);
    check("ab_imem_we", 64'(imem_we), 64'd0);
    cmd_op = OP_WR_IMEM;
    #1;
    check("ab_idle_ready", 64'(cmd_ready), 64'd1);

    // Asynchronous reset mid-RUN
    start_run(32'd0, "ar");
    measure_hold("ar");
    wait_count(32'd5, "ar");
    #3 rst = 1'b1;
    #1;
    check("ar_core_reset_x", 64'(core_reset_x), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_count", 64'(cycle_count), 64'd0);
    check("ar_done", 64'(done), 64'd0);
    tick();
    rst = 1'b0;
    start_run(32'd0, "ar2");
    measure_hold("ar2");
    tick();
    check("ar2_cnt1", 64'(cycle_count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
